// File: rtl/pic_inta_sequencer.sv
// rtl/pic_inta_sequencer.sv - 8259 INT/INTA sequencer with In-Service register and EOI handling
module pic_inta_sequencer #(
    parameter int         INTA_SYNC_STAGES = 2,
    parameter logic [2:0] LS_RESET         = 3'd7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       int_flag,
    input  logic [2:0] priority_id,
    input  logic       rotating_priority,
    input  logic       aeoi,
    input  logic [4:0] vector_base,
    input  logic       inta_n,
    input  logic       eoi_valid,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic       eoi_rotate,
    output logic       int_out,
    output logic [7:0] is_status,
    output logic [2:0] last_serviced,
    output logic [7:0] irr_clear,
    output logic [7:0] data_out,
    output logic       data_oe
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INT_PEND = 2'd1,
        ACK1     = 2'd2,
        ACK2     = 2'd3
    } state_t;

    state_t state, state_n;

    logic [INTA_SYNC_STAGES-1:0] inta_sync;
    logic                        inta_prev;
    logic                        inta_s;
    logic                        inta_fall;
    logic                        inta_rise;

    logic [2:0] cur_id, cur_id_n;
    logic       spurious, spurious_n;
    logic       int_out_n;
    logic [7:0] is_status_n;
    logic [2:0] last_serviced_n;
    logic [7:0] irr_clear_n;
    logic [7:0] data_out_n;
    logic       data_oe_n;

    logic       eoi_hit;
    logic [2:0] eoi_lvl;
    logic       eoi_rot;
    logic [7:0] eoi_clr;

    assign inta_s    = inta_sync[INTA_SYNC_STAGES-1];
    assign inta_fall = inta_prev & ~inta_s;
    assign inta_rise = ~inta_prev & inta_s;

    // Synchronize the asynchronous INTA strobe and keep its previous value for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            inta_sync <= '1;
            inta_prev <= 1'b1;
        end else begin
            inta_sync <= {inta_sync[INTA_SYNC_STAGES-2:0], inta_n};
            inta_prev <= inta_s;
        end
    end

    // Pick the level an EOI command clears, judged against the current In-Service register
    always_comb begin
        eoi_hit = 1'b0;
        eoi_lvl = 3'd0;
        if (eoi_valid) begin
            if (eoi_specific) begin
                eoi_hit = 1'b1;
                eoi_lvl = eoi_level;
            end else if (!rotating_priority) begin
                // Descending scan so the lowest set index is the last one written
                for (int i = 7; i >= 0; i--) begin
                    if (is_status[i]) begin
                        eoi_hit = 1'b1;
                        eoi_lvl = 3'(i);
                    end
                end
            end else begin
                // Scan from last_serviced+8 down to +1 so last_serviced+1 has final say
                for (int k = 8; k >= 1; k--) begin
                    if (is_status[last_serviced + 3'(k)]) begin
                        eoi_hit = 1'b1;
                        eoi_lvl = last_serviced + 3'(k);
                    end
                end
            end
        end
        eoi_clr = eoi_hit ? (8'b1 << eoi_lvl) : 8'h00;
        eoi_rot = eoi_hit & eoi_rotate;
    end

    // Handshake sequencing plus next values of every registered output
    always_comb begin
        logic [7:0] is_set;
        logic [7:0] aeoi_clr;
        logic       aeoi_rot;

        state_n         = state;
        cur_id_n        = cur_id;
        spurious_n      = spurious;
        int_out_n       = int_out;
        irr_clear_n     = 8'h00;
        data_out_n      = data_out;
        data_oe_n       = data_oe;
        is_set          = 8'h00;
        aeoi_clr        = 8'h00;
        aeoi_rot        = 1'b0;

        case (state)
            IDLE: begin
                int_out_n = 1'b0;
                data_oe_n = 1'b0;
                if (int_flag) begin
                    int_out_n = 1'b1;
                    state_n   = INT_PEND;
                end
            end
            INT_PEND: begin
                int_out_n = 1'b1;
                if (inta_fall) begin
                    if (int_flag) begin
                        cur_id_n    = priority_id;
                        spurious_n  = 1'b0;
                        is_set      = 8'b1 << priority_id;
                        irr_clear_n = 8'b1 << priority_id;
                    end else begin
                        // Request vanished before the acknowledge: hand out IR7
                        cur_id_n   = 3'd7;
                        spurious_n = 1'b1;
                    end
                    int_out_n = 1'b0;
                    state_n   = ACK1;
                end
            end
            ACK1: begin
                data_oe_n = 1'b0;
                if (inta_fall) begin
                    data_out_n = {vector_base, cur_id};
                    data_oe_n  = 1'b1;
                    state_n    = ACK2;
                end
            end
            ACK2: begin
                if (inta_rise) begin
                    data_oe_n = 1'b0;
                    if (aeoi && !spurious) begin
                        aeoi_clr = 8'b1 << cur_id;
                        aeoi_rot = rotating_priority;
                    end
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // A set in the same cycle as a clear of that bit leaves it set
        is_status_n = (is_status & ~(eoi_clr | aeoi_clr)) | is_set;

        if (eoi_rot)
            last_serviced_n = eoi_lvl;
        else if (aeoi_rot)
            last_serviced_n = cur_id;
        else
            last_serviced_n = last_serviced;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cur_id        <= 3'd0;
            spurious      <= 1'b0;
            int_out       <= 1'b0;
            is_status     <= 8'h00;
            last_serviced <= LS_RESET;
            irr_clear     <= 8'h00;
            data_out      <= 8'h00;
            data_oe       <= 1'b0;
        end else begin
            state         <= state_n;
            cur_id        <= cur_id_n;
            spurious      <= spurious_n;
            int_out       <= int_out_n;
            is_status     <= is_status_n;
            last_serviced <= last_serviced_n;
            irr_clear     <= irr_clear_n;
            data_out      <= data_out_n;
            data_oe       <= data_oe_n;
        end
    end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// tb/tb_pic_inta_sequencer.sv - randomized self-checking bench for pic_inta_sequencer
module tb_pic_inta_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       int_flag;
    logic [2:0] priority_id;
    logic       rotating_priority;
    logic       aeoi;
    logic [4:0] vector_base;
    logic       inta_n;
    logic       eoi_valid;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       eoi_rotate;
    logic       int_out;
    logic [7:0] is_status;
    logic [2:0] last_serviced;
    logic [7:0] irr_clear;
    logic [7:0] data_out;
    logic       data_oe;

    int checks   = 0;
    int failures = 0;

    logic [7:0] is_m;
    logic [2:0] ls_m;

    always #5 clk = ~clk;

    pic_inta_sequencer #(
        .INTA_SYNC_STAGES(2),
        .LS_RESET        (3'd7)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .int_flag         (int_flag),
        .priority_id      (priority_id),
        .rotating_priority(rotating_priority),
        .aeoi             (aeoi),
        .vector_base      (vector_base),
        .inta_n           (inta_n),
        .eoi_valid        (eoi_valid),
        .eoi_specific     (eoi_specific),
        .eoi_level        (eoi_level),
        .eoi_rotate       (eoi_rotate),
        .int_out          (int_out),
        .is_status        (is_status),
        .last_serviced    (last_serviced),
        .irr_clear        (irr_clear),
        .data_out         (data_out),
        .data_oe          (data_oe)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_int"},  32'(int_out),       32'd0);
        chk({tag, "_is"},   32'(is_status),     32'h00);
        chk({tag, "_ls"},   32'(last_serviced), 32'd7);
        chk({tag, "_irr"},  32'(irr_clear),     32'h00);
        chk({tag, "_dout"}, 32'(data_out),      32'h00);
        chk({tag, "_doe"},  32'(data_oe),       32'd0);
    endtask

    // Reference EOI: priority order is plain index order (fixed) or starts after ls (rotating)
    task automatic do_eoi(input bit spec, input logic [2:0] lvl, input bit rot);
        int clr;
        int idx;
        clr = -1;
        if (spec) begin
            clr = int'(lvl);
        end else if (is_m != 8'h00) begin
            for (int k = 0; k < 8; k++) begin
                idx = rotating_priority ? (int'(ls_m) + 1 + k) % 8 : k;
                if (clr < 0 && is_m[idx]) clr = idx;
            end
        end
        if (clr >= 0) begin
            is_m[clr] = 1'b0;
            if (rot) ls_m = 3'(clr);
        end
        eoi_valid    = 1'b1;
        eoi_specific = spec;
        eoi_level    = lvl;
        eoi_rotate   = rot;
        step();
        eoi_valid = 1'b0;
        chk("eoi_is", 32'(is_status),     32'(is_m));
        chk("eoi_ls", 32'(last_serviced), 32'(ls_m));
    endtask

    // One full INT + two-pulse INTA transaction with fixed synchronizer latency of 3 cycles
    task automatic do_irq(input bit spur, input logic [2:0] id);
        logic [2:0] cid;
        int_flag    = 1'b1;
        priority_id = id;
        step();
        chk("int_rise", 32'(int_out), 32'd1);
        if (spur) int_flag = 1'b0;
        step();
        chk("int_hold", 32'(int_out), 32'd1);
        inta_n = 1'b0;
        step();
        step();
        chk("lat_int", 32'(int_out),   32'd1);
        chk("lat_irr", 32'(irr_clear), 32'h00);
        step();
        cid = spur ? 3'd7 : id;
        if (!spur) is_m[id] = 1'b1;
        chk("ack1_int", 32'(int_out),   32'd0);
        chk("ack1_irr", 32'(irr_clear), spur ? 32'h00 : (32'd1 << id));
        chk("ack1_is",  32'(is_status), 32'(is_m));
        chk("ack1_doe", 32'(data_oe),   32'd0);
        int_flag = 1'b0;
        step();
        chk("irr_pulse", 32'(irr_clear), 32'h00);
        inta_n = 1'b1;
        repeat (4) step();
        chk("gap_doe", 32'(data_oe), 32'd0);
        inta_n = 1'b0;
        repeat (3) step();
        chk("ack2_dout", 32'(data_out), 32'({vector_base, cid}));
        chk("ack2_doe",  32'(data_oe),  32'd1);
        inta_n = 1'b1;
        repeat (2) step();
        chk("ack2_hold", 32'(data_oe), 32'd1);
        step();
        if (aeoi && !spur) begin
            is_m[cid] = 1'b0;
            if (rotating_priority) ls_m = cid;
        end
        chk("end_doe",  32'(data_oe),       32'd0);
        chk("end_dout", 32'(data_out),      32'({vector_base, cid}));
        chk("end_is",   32'(is_status),     32'(is_m));
        chk("end_ls",   32'(last_serviced), 32'(ls_m));
        chk("end_int",  32'(int_out),       32'd0);
        step();
    endtask

    initial begin
        rst               = 1'b1;
        int_flag          = 1'b0;
        priority_id       = 3'd0;
        rotating_priority = 1'b0;
        aeoi              = 1'b0;
        vector_base       = 5'b01000;
        inta_n            = 1'b1;
        eoi_valid         = 1'b0;
        eoi_specific      = 1'b0;
        eoi_level         = 3'd0;
        eoi_rotate        = 1'b0;
        is_m              = 8'h00;
        ls_m              = 3'd7;
        step();
        step();
        chk_reset_outputs("rst0");
        rst = 1'b0;
        step();

        // Fixed-priority vector for IR1 with base 01000 is 8'h41
        do_irq(1'b0, 3'd1);
        // Spurious acknowledge returns IR7 and leaves IS untouched
        do_irq(1'b1, 3'd3);

        for (int n = 0; n < 60; n++) begin
            rotating_priority = 1'($urandom_range(0, 1));
            aeoi              = ($urandom_range(0, 2) == 0);
            vector_base       = 5'($urandom);
            do_irq($urandom_range(0, 4) == 0, 3'($urandom));
            if ($urandom_range(0, 1) == 1)
                do_eoi($urandom_range(0, 3) == 0, 3'($urandom), 1'($urandom_range(0, 1)));
        end
        // Drain IS with non-specific EOIs, including a no-op on an empty register
        for (int n = 0; n < 9; n++)
            do_eoi(1'b0, 3'd0, 1'($urandom_range(0, 1)));

        // Reset while the vector is being driven aborts the handshake
        int_flag    = 1'b1;
        priority_id = 3'd5;
        step();
        int_flag = 1'b0;
        inta_n   = 1'b0;
        repeat (3) step();
        inta_n = 1'b1;
        repeat (4) step();
        inta_n = 1'b0;
        repeat (3) step();
        chk("pre_rst_doe", 32'(data_oe), 32'd1);
        rst    = 1'b1;
        inta_n = 1'b1;
        step();
        chk_reset_outputs("rst_ack2");
        rst  = 1'b0;
        is_m = 8'h00;
        ls_m = 3'd7;
        repeat (4) step();
        chk("post_rst_int", 32'(int_out), 32'd0);
        chk("post_rst_doe", 32'(data_oe), 32'd0);
        aeoi = 1'b0;
        do_irq(1'b0, 3'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
